// File: rtl/scanline_buffer.sv
// -----------------------------------------------------------------------------
// scanline_buffer
//
// Ping-pong line buffer sitting between the pixel renderer and the VGA pins.
// The renderer fills the back bank with one complete line (valid/ready).
// The front bank is read at the timing generator's x coordinate.
// Each rendered line is shown for LINE_REPEAT display lines.
// Colour, hsync and vsync leave the block aligned with a 2-cycle latency.
//
// Optional feature: define SCANLINE_BORDER_EN to add parameter BORDER_COLOR.
// Blank pixels inside the visible area (past the end of the line, or no valid
// front line) then show BORDER_COLOR. Pixels outside the visible area stay 0.
// Without the macro every blank pixel is 0.
//
// Ports:
//   clk        pixel clock (shared with the timing generator)
//   rst        synchronous active-high reset
//   hsync_in   active-low hsync from the timing generator
//   vsync_in   active-low vsync from the timing generator
//   xp         pixel x coordinate (ignored outside the visible area)
//   visible    display-area flag
//   wr_valid   renderer presents a pixel on wr_color
//   wr_color   pixel colour, written left to right
//   wr_ready   back bank can accept a pixel
//   line_full  back bank holds a complete line
//   color      pixel colour to the DAC
//   hsync      hsync_in delayed by 2 cycles
//   vsync      vsync_in delayed by 2 cycles
//   underrun   sticky: a swap found the back bank incomplete
// -----------------------------------------------------------------------------
module scanline_buffer #(
    parameter int COLOR_W     = 6,
    parameter int LINE_PIXELS = 256,
    parameter int LINE_REPEAT = 2
`ifdef SCANLINE_BORDER_EN
    ,
    parameter logic [COLOR_W-1:0] BORDER_COLOR = COLOR_W'(6'h15)
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic [7:0]         xp,
    input  logic               visible,
    input  logic               wr_valid,
    input  logic [COLOR_W-1:0] wr_color,
    output logic               wr_ready,
    output logic               line_full,
    output logic [COLOR_W-1:0] color,
    output logic               hsync,
    output logic               vsync,
    output logic               underrun
);

    // Bank addresses are {bank, pixel}; the 8-bit fill pointer and 8-bit xp
    // cover exactly one 256-pixel bank.
    localparam int FILL_W = 8;
    localparam int COL_W  = 9;
    localparam int REP_W  = $clog2(LINE_REPEAT + 1);
    localparam int ADDR_W = FILL_W + 1;
    localparam int DEPTH  = 2 * LINE_PIXELS;

    localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(LINE_PIXELS - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(LINE_REPEAT - 1);
    localparam logic [COL_W-1:0]  COL_LINE  = COL_W'(LINE_PIXELS);
    localparam logic [COL_W-1:0]  COL_MAX   = '1;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic              bank_sel_reg,    bank_sel_next;     // front bank index
    logic [FILL_W-1:0] fill_reg,        fill_next;
    logic              line_full_reg,   line_full_next;
    logic [REP_W-1:0]  rep_reg,         rep_next;
    logic              front_valid_reg, front_valid_next;
    logic              underrun_reg,    underrun_next;
    logic [COL_W-1:0]  col_reg,         col_next;
    logic              vsync_prev_reg;
    logic              visible_prev_reg;

    // Read pipeline, stage 1
    logic [COLOR_W-1:0] rd_data_reg;
    logic               s1_visible_reg;
    logic               s1_front_valid_reg;
    logic               s1_in_line_reg;
    logic               s1_hsync_reg;
    logic               s1_vsync_reg;

    // Read pipeline, stage 2 (outputs)
    logic [COLOR_W-1:0] color_reg, color_next;
    logic               hsync_reg;
    logic               vsync_reg;

    // Combinational helpers
    logic               wr_fire;
    logic               last_write;
    logic               frame_start;
    logic               line_end;
    logic               swap_req;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  rd_addr;
    logic [COLOR_W-1:0] blank_color;

    // Line storage: two banks, written on the back side, read on the front.
    logic [COLOR_W-1:0] mem [0:DEPTH-1];

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    assign wr_ready   = !rst && !line_full_reg;
    assign wr_fire    = wr_valid && wr_ready;
    assign last_write = wr_fire && (fill_reg == LAST_FILL);

    // The back bank is always the one not selected for display.
    assign wr_addr = {~bank_sel_reg, fill_reg};
    assign rd_addr = {bank_sel_reg, xp};

    // Edge detects against the registered previous input values. The
    // pulse is high only in the first cycle after the transition.
    assign frame_start = vsync_prev_reg && !vsync_in;
    assign line_end    = visible_prev_reg && !visible;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_addr] <= wr_color;
        end
        rd_data_reg <= mem[rd_addr];
    end

    // ------------------------------------------------------------------
    // Next-state logic: fill pointer, repeat counter and bank swap
    // ------------------------------------------------------------------
    always_comb begin
        bank_sel_next    = bank_sel_reg;
        fill_next        = fill_reg;
        line_full_next   = line_full_reg;
        rep_next         = rep_reg;
        front_valid_next = front_valid_reg;
        underrun_next    = underrun_reg;
        swap_req         = 1'b0;

        if (wr_fire) begin
            fill_next = last_write ? '0 : fill_reg + 1'b1;
        end

        // A frame start takes priority and realigns the repeat count so
        // every frame begins on a fresh rendered line.
        if (frame_start) begin
            rep_next = '0;
            swap_req = 1'b1;
        end else if (line_end) begin
            if (rep_reg == REP_LAST) begin
                rep_next = '0;
                swap_req = 1'b1;
            end else begin
                rep_next = rep_reg + 1'b1;
            end
        end

        if (swap_req) begin
            // A pixel completing the line in the swap cycle still lands in
            // the old back bank, which is exactly the bank becoming front.
            if (line_full_reg || last_write) begin
                bank_sel_next    = ~bank_sel_reg;
                line_full_next   = 1'b0;
                front_valid_next = 1'b1;
            end else begin
                // Keep the partial line; it swaps in once completed.
                front_valid_next = 1'b0;
                underrun_next    = 1'b1;
            end
        end else if (last_write) begin
            line_full_next = 1'b1;
        end
    end

    // Column counter saturates so a very long visible period never wraps
    // back into the line area.
    always_comb begin
        col_next = '0;
        if (visible) begin
            col_next = (col_reg == COL_MAX) ? col_reg : col_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output colour selection
    // ------------------------------------------------------------------
    always_comb begin
`ifdef SCANLINE_BORDER_EN
        blank_color = s1_visible_reg ? BORDER_COLOR : '0;
`else
        blank_color = '0;
`endif
        color_next = blank_color;
        if (s1_visible_reg && s1_front_valid_reg && s1_in_line_reg) begin
            color_next = rd_data_reg;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_sel_reg       <= 1'b0;
            fill_reg           <= '0;
            line_full_reg      <= 1'b0;
            rep_reg            <= '0;
            front_valid_reg    <= 1'b0;
            underrun_reg       <= 1'b0;
            col_reg            <= '0;
            vsync_prev_reg     <= 1'b1;
            visible_prev_reg   <= 1'b0;
            s1_visible_reg     <= 1'b0;
            s1_front_valid_reg <= 1'b0;
            s1_in_line_reg     <= 1'b0;
            s1_hsync_reg       <= 1'b1;
            s1_vsync_reg       <= 1'b1;
            color_reg          <= '0;
            hsync_reg          <= 1'b1;
            vsync_reg          <= 1'b1;
        end else begin
            bank_sel_reg       <= bank_sel_next;
            fill_reg           <= fill_next;
            line_full_reg      <= line_full_next;
            rep_reg            <= rep_next;
            front_valid_reg    <= front_valid_next;
            underrun_reg       <= underrun_next;
            col_reg            <= col_next;
            vsync_prev_reg     <= vsync_in;
            visible_prev_reg   <= visible;
            s1_visible_reg     <= visible;
            s1_front_valid_reg <= front_valid_reg;
            s1_in_line_reg     <= (col_reg < COL_LINE);
            s1_hsync_reg       <= hsync_in;
            s1_vsync_reg       <= vsync_in;
            color_reg          <= color_next;
            hsync_reg          <= s1_hsync_reg;
            vsync_reg          <= s1_vsync_reg;
        end
    end

    assign line_full = line_full_reg;
    assign underrun  = underrun_reg;
    assign color     = color_reg;
    assign hsync     = hsync_reg;
    assign vsync     = vsync_reg;

endmodule

// File: tb/tb_scanline_buffer.sv
// -----------------------------------------------------------------------------
// tb_scanline_buffer
//
// Drives a simple timing generator and renderer into scanline_buffer and
// checks every output on every cycle against a line-level reference model:
// the model keeps the displayed line and the line being filled as plain
// arrays, copies one into the other at each successful swap, and predicts the
// output stream two cycles later. Directed sections add literal expectations.
// -----------------------------------------------------------------------------
module tb_scanline_buffer;

    localparam int COLOR_W     = 6;
    localparam int LINE_PIXELS = 256;
    localparam int LINE_REPEAT = 2;
`ifdef SCANLINE_BORDER_EN
    localparam logic [5:0] BLANK = 6'h15;
`else
    localparam logic [5:0] BLANK = 6'h00;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               hsync_in;
    logic               vsync_in;
    logic [7:0]         xp;
    logic               visible;
    logic               wr_valid;
    logic [COLOR_W-1:0] wr_color;
    logic               wr_ready;
    logic               line_full;
    logic [COLOR_W-1:0] color;
    logic               hsync;
    logic               vsync;
    logic               underrun;

    scanline_buffer #(
        .COLOR_W    (COLOR_W),
        .LINE_PIXELS(LINE_PIXELS),
        .LINE_REPEAT(LINE_REPEAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .xp       (xp),
        .visible  (visible),
        .wr_valid (wr_valid),
        .wr_color (wr_color),
        .wr_ready (wr_ready),
        .line_full(line_full),
        .color    (color),
        .hsync    (hsync),
        .vsync    (vsync),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [5:0] m_front [LINE_PIXELS];   // line currently displayed
    logic [5:0] m_back  [LINE_PIXELS];   // line being filled
    int         m_fill;
    bit         m_full, m_fv, m_under, m_init = 0;
    int         m_rep, m_col;
    bit         m_vs_prev, m_vis_prev;
    logic [5:0] e_color, p_color;        // e_* = output now, p_* = next
    bit         e_hs, e_vs, p_hs, p_vs;
    bit         m_last, m_ev;

    always @(posedge clk) begin
        if (rst) begin
            m_init = 1; m_fill = 0; m_full = 0; m_fv = 0; m_under = 0;
            m_rep = 0; m_col = 0; m_vs_prev = 1; m_vis_prev = 0;
            e_color = 0; p_color = 0; e_hs = 1; e_vs = 1; p_hs = 1; p_vs = 1;
        end else begin
            e_color = p_color; e_hs = p_hs; e_vs = p_vs;
            if (!visible)                           p_color = 6'h00;
            else if (m_fv && m_col < LINE_PIXELS)   p_color = m_front[xp];
            else                                    p_color = BLANK;
            p_hs = hsync_in; p_vs = vsync_in;

            m_last = 0;
            if (wr_valid && !m_full) begin
                m_back[m_fill] = wr_color;
                m_fill++;
                if (m_fill == LINE_PIXELS) begin m_fill = 0; m_last = 1; end
            end

            m_ev = 0;
            if (m_vs_prev && !vsync_in) begin
                m_rep = 0; m_ev = 1;
            end else if (m_vis_prev && !visible) begin
                m_rep++;
                if (m_rep == LINE_REPEAT) begin m_rep = 0; m_ev = 1; end
            end

            if (m_ev) begin
                if (m_full || m_last) begin
                    m_front = m_back; m_full = 0; m_fv = 1;
                end else begin
                    m_fv = 0; m_under = 1;
                end
            end else if (m_last) begin
                m_full = 1;
            end

            m_col = visible ? m_col + 1 : 0;
            m_vs_prev = vsync_in; m_vis_prev = visible;
        end
    end

    // Compare process: every output, every cycle, away from the clock edge.
    always @(negedge clk) begin
        if (m_init) begin
            chk("color",     color,     e_color);
            chk("hsync",     hsync,     e_hs);
            chk("vsync",     vsync,     e_vs);
            chk("underrun",  underrun,  m_under);
            chk("line_full", line_full, m_full);
            chk("wr_ready",  wr_ready,  !rst && !m_full);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus: renderer state advanced inside step()
    // ------------------------------------------------------------------
    int         ren_budget = 0;   // pixels still to push
    int         ren_idx    = 0;   // pixel index for patterned lines
    int         ren_duty   = 100; // percent of cycles with wr_valid
    bit         ren_pat    = 0;   // patterned (idx ^ xor) or random colours
    logic [5:0] ren_xor    = 0;
    logic       rdy_s;

    task automatic step();
        logic [31:0] t;
        @(negedge clk);
        rdy_s = wr_ready;
        @(posedge clk);
        if (wr_valid && rdy_s) begin ren_budget--; ren_idx++; end
        #1;
        wr_valid = (ren_budget > 0) && ($urandom_range(99) < ren_duty);
        t = ren_idx;
        wr_color = ren_pat ? (t[5:0] ^ ren_xor) : 6'($urandom);
    endtask

    task automatic wait_budget(input int lim);
        int n = 0;
        while (ren_budget > 0 && n < lim) begin step(); n++; end
        if (ren_budget > 0) begin
            n_total++;
            $display("FAIL wait_budget: got %0d pixels left expected 0", ren_budget);
        end
    endtask

    // One display line: vis_len visible cycles then a 16-cycle hblank.
    // lit: also check colours literally against pattern idx ^ lx.
    // final_at_fall: push one last pixel in the first hblank cycle.
    task automatic do_line(input int vis_len, input bit lit, input logic [5:0] lx,
                           input bit final_at_fall);
        logic [31:0] c32;
        logic [5:0]  want;
        for (int c = 0; c < vis_len; c++) begin
            visible = 1; c32 = c; xp = c32[7:0]; hsync_in = 1;
            if (final_at_fall && c == vis_len - 1) ren_budget = 1;
            step();
            if (lit && c >= 1) begin
                c32 = c - 1;
                want = (c - 1 < LINE_PIXELS) ? (c32[5:0] ^ lx) : BLANK;
                chk("lit_color", color, want);
            end
        end
        for (int h = 0; h < 16; h++) begin
            visible = 0; xp = 8'($urandom); hsync_in = !(h >= 4 && h < 10);
            step();
            if (lit && h == 0) begin
                c32 = vis_len - 1;
                want = (vis_len - 1 < LINE_PIXELS) ? (c32[5:0] ^ lx) : BLANK;
                chk("lit_last_color", color, want);
            end
            if (lit && h == 4) chk("lit_hsync_hold", hsync, 1);
            if (lit && h == 5) chk("lit_hsync_fall", hsync, 0);
        end
    endtask

    task automatic do_vsync();
        visible = 0; hsync_in = 1;
        vsync_in = 0; repeat (4) step();
        vsync_in = 1; repeat (6) step();
    endtask

    initial begin
        rst = 1; hsync_in = 1; vsync_in = 1; visible = 0; xp = 0;
        wr_valid = 0; wr_color = 0;
        repeat (3) step();
        chk("rst_color", color, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_underrun", underrun, 0);
        chk("rst_line_full", line_full, 0);
        chk("rst_wr_ready", wr_ready, 0);
        rst = 0;

        // Line A = i[5:0], loaded during vblank.
        ren_pat = 1; ren_xor = 0; ren_idx = 0; ren_duty = 100; ren_budget = 256;
        wait_budget(400);
        chk("a_full", line_full, 1);
        chk("a_not_ready", wr_ready, 0);
        repeat (3) step();

        // Frame start swaps A to front.
        vsync_in = 0; step();
        chk("swap_clears_full", line_full, 0);
        repeat (3) step();
        vsync_in = 1; repeat (6) step();

        // Lines 0,1 show A while random line B is filled.
        ren_pat = 0; ren_idx = 0; ren_budget = 256;
        do_line(320, 1, 6'h00, 0);
        chk("b_full", line_full, 1);
        do_line(320, 1, 6'h00, 0);

        // Lines 2,3 show B; line C (idx ^ 3F) completes on the swap cycle.
        ren_pat = 1; ren_xor = 6'h3F; ren_idx = 0; ren_budget = 255;
        do_line(320, 0, 6'h00, 0);
        do_line(320, 0, 6'h00, 1);
        chk("simul_full", line_full, 0);
        chk("simul_underrun", underrun, 0);
        do_line(320, 1, 6'h3F, 0);

        // Underrun: only 100 pixels before the swap after line 5.
        ren_pat = 0; ren_budget = 100;
        do_line(320, 0, 6'h00, 0);
        chk("underrun_set", underrun, 1);
        chk("underrun_not_full", line_full, 0);
        do_line(300, 0, 6'h00, 0);
        ren_budget = 155; wait_budget(400);
        chk("partial_155", line_full, 0);
        ren_budget = 1; wait_budget(50);
        chk("partial_156", line_full, 1);
        do_line(320, 0, 6'h00, 0);
        chk("late_swap", line_full, 0);
        do_line(320, 0, 6'h00, 0);
        do_line(260, 0, 6'h00, 0);

        // Random frames.
        for (int f = 0; f < 4; f++) begin
            do_vsync();
            for (int l = 0; l < 6; l++) begin
                ren_budget = $urandom_range(300, 100);
                ren_duty   = $urandom_range(100, 60);
                do_line($urandom_range(320, 240), 0, 6'h00, 0);
            end
        end

        // Reset mid-line with 50 pixels written.
        ren_budget = 0; ren_duty = 100; ren_pat = 1; ren_xor = 0; ren_idx = 0;
        rst = 1; step(); rst = 0; step();
        ren_budget = 50;
        for (int c = 0; c < 60; c++) begin
            logic [31:0] c32;
            visible = 1; c32 = c; xp = c32[7:0]; step();
        end
        chk("fill50_done", ren_budget, 0);
        rst = 1; hsync_in = 0; vsync_in = 0; step();
        chk("mid_rst_color", color, 0);
        chk("mid_rst_hsync", hsync, 1);
        chk("mid_rst_vsync", vsync, 1);
        chk("mid_rst_underrun", underrun, 0);
        chk("mid_rst_line_full", line_full, 0);
        chk("mid_rst_wr_ready", wr_ready, 0);
        rst = 0; hsync_in = 1; vsync_in = 1; visible = 0; step();
        chk("post_rst_ready", wr_ready, 1);
        ren_budget = 255; wait_budget(400);
        chk("refill_255", line_full, 0);
        ren_budget = 1; wait_budget(50);
        chk("refill_256", line_full, 1);
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/scanline_buffer.md
Name: scanline_buffer

Overview:
- Ping-pong scanline buffer between the pixel renderer and the VGA pins, directly downstream of the video timing generator.
- The renderer pushes one 256-pixel line into the back bank over a valid/ready handshake.
- The front bank is read at the timing generator's pixel coordinate, with line repetition for vertical doubling.
- Colour, hsync and vsync leave the block aligned, with a fixed 2-cycle latency.

Parameters:
- COLOR_W, 6, bits per pixel colour word.
- LINE_PIXELS, 256, pixels per rendered line (bank depth).
- LINE_REPEAT, 2, number of visible display lines each rendered line is shown for.

Ports:
- clk  input  1  pixel clock, same clock as the timing generator.
- rst  input  1  reset, synchronous, active-high.
- hsync_in  input  1  active-low hsync from the timing generator.
- vsync_in  input  1  active-low vsync from the timing generator.
- xp  input  8  pixel x coordinate; don't-care when visible=0.
- visible  input  1  display-area flag from the timing generator.
- wr_valid  input  1  renderer has a pixel on wr_color.
- wr_color  input  COLOR_W  pixel colour, left to right order.
- wr_ready  output  1  back bank can accept a pixel.
- line_full  output  1  back bank holds a complete line.
- color  output  COLOR_W  pixel colour to the DAC.
- hsync  output  1  hsync_in delayed 2 cycles.
- vsync  output  1  vsync_in delayed 2 cycles.
- underrun  output  1  sticky flag: a swap found the back bank incomplete.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - color=0, hsync=1, vsync=1, underrun=0, line_full=0, wr_ready=0.
  - bank select=0, fill pointer=0, repeat counter=0, front_valid=0, column counter=0.
  - Both sync delay stages are set to 1.
- Reset mid-frame or mid-fill abandons any partial line; RAM contents are not cleared.
- Write side:
  - wr_ready = !rst && !line_full.
  - A transfer occurs when wr_valid && wr_ready. It writes wr_color to back[fill], then fill increments.
  - When fill reaches LINE_PIXELS-1 and a transfer occurs, line_full is set the next cycle and fill returns to 0.
- Swap events (registered edge detect, one-cycle pulse):
  - (a) vsync_in falling edge (frame start): repeat counter cleared to 0, then the swap rule applies.
  - (b) visible falling edge: repeat counter increments. If it reaches LINE_REPEAT it clears to 0 and the swap rule applies; otherwise no swap.
- Swap rule:
  - If line_full: toggle bank select, clear line_full, set front_valid=1.
  - Else: front_valid=0, underrun set sticky (cleared only by rst); fill and the partial line are kept.
- Simultaneous events:
  - A swap in the same cycle as the final write counts as full; that pixel lands in the old back bank, which becomes front.
  - Any other write in the swap cycle goes to the pre-swap back bank.
- Read side:
  - Column counter increments each visible cycle and clears when visible=0.
  - Stage 1 registers the front-bank read at address xp, plus visible, front_valid, (col < LINE_PIXELS), hsync_in and vsync_in.
  - Stage 2 drives the outputs: color = mem data if all stage-1 flags are true, else the blank colour.
- Latency: xp to color, hsync_in to hsync, vsync_in to vsync are all exactly 2 cycles.
- Widths: fill is 8 bits, column counter 9 bits, repeat counter $clog2(LINE_REPEAT+1) bits.

Optional Feature:
- Macro SCANLINE_BORDER_EN.
- Defined: adds parameter BORDER_COLOR (default 6'h15). Blank pixels inside visible (col >= LINE_PIXELS, or front_valid=0) output BORDER_COLOR. Pixels outside visible stay 0.
- Undefined: all blank pixels output 0 and BORDER_COLOR does not exist.

Test Plan:
- Reset, then stream 256 pixels with value i[5:0] during vblank, then start a frame → line_full=1 after pixel 255 with wr_ready=0. At the vsync edge a swap occurs and line_full=0. On line 0, color at cycle t+2 equals xp[5:0] for xp 0..255.
- Visible columns 256..319 → color=0 (BORDER_COLOR when SCANLINE_BORDER_EN is defined). Hsync/vsync edges appear exactly 2 cycles after the inputs.
- LINE_REPEAT=2 with line A loaded and line B filled early → display lines 0 and 1 show A, lines 2 and 3 show B. No swap occurs at the end of line 0.
- Only 100 pixels written before a swap event → underrun=1, next line all blank, fill stays 100. Completing 156 more pixels then swaps at the next event.
- Final write in the same cycle as the swap pulse → swap taken, the written line displays correctly, underrun stays 0.
- Assert rst mid-line with fill=50 → next cycle all outputs at reset values and wr_ready=0. After release, fill restarts at 0 and wr_ready=1.
